// File: rtl/sarray_storec.sv
// Store-C engine: issues a drain command to the systolic array, buffers the
// result rows from its bottom edge, and writes them to memory one row at a time.
module sarray_storec #(
  parameter int ADDR_WIDTH  = 64,
  parameter int STORE_WIDTH = 512,
  parameter int CNT_WIDTH   = 6,
  parameter int ROWS        = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROW_SHIFT   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   storec_valid_i,
  output logic                   storec_ready_o,
  input  logic [ADDR_WIDTH-1:0]  storec_addr_i,
  output logic                   post_storec_valid_o,
  input  logic                   bot_valid_i,
  input  logic [CNT_WIDTH-1:0]   bot_cnt_i,
  input  logic [STORE_WIDTH-1:0] bot_data_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [ADDR_WIDTH-1:0]  aw_addr_o,
  output logic [STORE_WIDTH-1:0] aw_data_o,
  output logic                   storec_finished_o,
  output logic                   overflow_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int ROW_W = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    POST,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0]  base;
  logic [ROW_W-1:0]       row_cnt;
  logic [STORE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]   fifo_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occupancy;
  logic                   overflow;

  logic accept;
  logic empty;
  logic full;
  logic push_req;
  logic push;
  logic drop;
  logic aw_fire;
  logic last_row;

  // Pointers wrap explicitly so a non-power-of-two depth still indexes safely.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign accept   = storec_valid_i && (state == IDLE);
  assign empty    = (occupancy == '0);
  assign full     = (occupancy == OCC_W'(FIFO_DEPTH));
  assign push_req = bot_valid_i && (state == DRAIN);
  assign aw_fire  = aw_valid_o && aw_ready_i;
  assign push     = push_req && (!full || aw_fire);
  assign drop     = push_req && full && !aw_fire;
  assign last_row = aw_fire && (row_cnt == ROW_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = POST;
      POST:    state_next = DRAIN;
      DRAIN:   if (last_row) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    storec_ready_o      = (state == IDLE);
    post_storec_valid_o = (state == POST);
    storec_finished_o   = (state == DONE);
    aw_valid_o          = (state == DRAIN) && !empty;
    aw_addr_o           = '0;
    aw_data_o           = '0;
    // Payload is forced to zero whenever nothing is presented, which also
    // keeps the unreset storage array from showing through during reset.
    if (aw_valid_o) begin
      aw_addr_o = base + (ADDR_WIDTH'(fifo_cnt[rd_ptr]) << ROW_SHIFT);
      aw_data_o = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      row_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        base      <= storec_addr_i;
        row_cnt   <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occupancy <= '0;
      end else begin
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (aw_fire) begin
          rd_ptr  <= ptr_inc(rd_ptr);
          row_cnt <= row_cnt + ROW_W'(1);
        end
        case ({push, aw_fire})
          2'b10:   occupancy <= occupancy + OCC_W'(1);
          2'b01:   occupancy <= occupancy - OCC_W'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bot_data_i;
      fifo_cnt[wr_ptr]  <= bot_cnt_i;
    end
  end

  assign overflow_o = overflow;

endmodule
